wb_regfile_scoreboard: RTL and testbench

// Write-back end of the EX/WB interface: consumes the latched write data, 3-bit register address and write enable

---
 rtl/wb_regfile_scoreboard.sv | 114 +++++++++++
 tb/tb_wb_regfile_scoreboard.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_scoreboard.sv
// Write-back register file with RAW scoreboard.
// Commits EX/WB results to the architectural registers, serves two combinational
// read ports with same-cycle write-through, and keeps a per-register count of
// issued-but-not-retired writes so decode can stall on read-after-write hazards.
module wb_regfile_scoreboard #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic [ADDR_W-1:0]    rd_addr_a,
   output logic [DATA_W-1:0]    rd_data_a,
   input  logic [ADDR_W-1:0]    rd_addr_b,
   output logic [DATA_W-1:0]    rd_data_b,
   input  logic                 issue_valid,
   input  logic [ADDR_W-1:0]    issue_dst,
   input  logic                 issue_wr,
   input  logic                 use_a,
   input  logic                 use_b,
   output logic                 stall,
   output logic [2**ADDR_W-1:0] busy_mask
);

   localparam int NREGS = 2**ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DATA_W-1:0] regs     [NREGS];
   logic [CNT_W-1:0]  cnt      [NREGS];
   logic [CNT_W-1:0]  cnt_next [NREGS];
   logic [NREGS-1:0]  ret_hit;
   logic [NREGS-1:0]  inc_hit;
   logic [NREGS-1:0]  eff_busy;
   logic              acc;
   logic              hit_a;
   logic              hit_b;

   // Write-through read ports; the bypass is gated off while reset is held so
   // reads return the cleared register contents.
   always_comb begin
      hit_a     = reset && wr_en && (wr_addr == rd_addr_a);
      hit_b     = reset && wr_en && (wr_addr == rd_addr_b);
      rd_data_a = hit_a ? wr_data : regs[rd_addr_a];
      rd_data_b = hit_b ? wr_data : regs[rd_addr_b];
   end

   // Per-register retire match and effective busy (count not covered by a
   // retire landing this very cycle).
   always_comb begin
      ret_hit  = '0;
      eff_busy = '0;
      for (int r = 0; r < NREGS; r++) begin
         ret_hit[r]  = wr_en && (wr_addr == ADDR_W'(r));
         eff_busy[r] = (cnt[r] != '0) && !((cnt[r] == CNT_ONE) && ret_hit[r]);
      end
   end

   // Issue hazard check; a full counter refuses issue even if it retires now.
   always_comb begin
      stall = issue_valid &&
              ((use_a && eff_busy[rd_addr_a]) ||
               (use_b && eff_busy[rd_addr_b]) ||
               (issue_wr && (cnt[issue_dst] == CNT_MAX)));
      acc   = issue_valid && !stall;
   end

   // Next-state counters: accept increments, retire decrements, both cancel,
   // and a retire against an empty counter holds it at zero.
   always_comb begin
      inc_hit = '0;
      for (int r = 0; r < NREGS; r++) begin
         inc_hit[r]  = acc && issue_wr && (issue_dst == ADDR_W'(r));
         cnt_next[r] = cnt[r];
         if (inc_hit[r] && !ret_hit[r]) begin
            cnt_next[r] = cnt[r] + CNT_ONE;
         end else if (inc_hit[r] && ret_hit[r] && (cnt[r] == '0)) begin
            cnt_next[r] = cnt[r] + CNT_ONE;
         end else if (!inc_hit[r] && ret_hit[r] && (cnt[r] != '0)) begin
            cnt_next[r] = cnt[r] - CNT_ONE;
         end
      end
   end

   // Architectural register write port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
         end
      end else if (wr_en) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Scoreboard counters and the registered busy view derived from them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NREGS; r++) begin
            cnt[r] <= '0;
         end
         busy_mask <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            cnt[r]       <= cnt_next[r];
            busy_mask[r] <= (cnt_next[r] != '0);
         end
      end
   end

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed bench for wb_regfile_scoreboard.
module tb_wb_regfile_scoreboard;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic [2:0] rd_addr_a;
   logic [7:0] rd_data_a;
   logic [2:0] rd_addr_b;
   logic [7:0] rd_data_b;
   logic       issue_valid;
   logic [2:0] issue_dst;
   logic       issue_wr;
   logic       use_a;
   logic       use_b;
   logic       stall;
   logic [7:0] busy_mask;

   int checks = 0;
   int passed = 0;

   wb_regfile_scoreboard #(.DATA_W(8), .ADDR_W(3), .CNT_W(2)) dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
      .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
      .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_wr(issue_wr),
      .use_a(use_a), .use_b(use_b),
      .stall(stall), .busy_mask(busy_mask)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic idle();
      wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
      issue_valid = 1'b0; issue_dst = 3'd0; issue_wr = 1'b0;
      use_a = 1'b0; use_b = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle();
      rd_addr_a = 3'd5; rd_addr_b = 3'd2;
      issue_valid = 1'b1; use_a = 1'b1; rd_addr_a = 3'd5;
      #1;
      checks++; if (rd_data_a !== 8'h00) $display("FAIL reset_rd_a got %h exp 00", rd_data_a); else passed++;
      checks++; if (busy_mask !== 8'h00) $display("FAIL reset_busy got %h exp 00", busy_mask); else passed++;
      checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else passed++;
      @(negedge clk);
      idle();
      reset = 1'b1;
   endtask

   task automatic test_write_read();
      @(negedge clk);
      idle();
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'hA7;
      rd_addr_a = 3'd5; rd_addr_b = 3'd5;
      #1;
      checks++; if (rd_data_a !== 8'hA7) $display("FAIL bypass_a got %h exp a7", rd_data_a); else passed++;
      checks++; if (rd_data_b !== 8'hA7) $display("FAIL bypass_b got %h exp a7", rd_data_b); else passed++;
      @(negedge clk);
      idle();
      #1;
      checks++; if (rd_data_a !== 8'hA7) $display("FAIL stored_a got %h exp a7", rd_data_a); else passed++;
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h3C;
      @(negedge clk);
      idle();
      rd_addr_b = 3'd0;
      #1;
      checks++; if (rd_data_b !== 8'h3C) $display("FAIL reg0_writable got %h exp 3c", rd_data_b); else passed++;
      checks++; if (rd_data_a !== 8'hA7) $display("FAIL reg5_kept got %h exp a7", rd_data_a); else passed++;
   endtask

   task automatic test_raw_stall();
      @(negedge clk);
      idle();
      issue_valid = 1'b1; issue_dst = 3'd3; issue_wr = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) $display("FAIL raw_issue_stall got %b exp 0", stall); else passed++;
      @(posedge clk); #1;
      checks++; if (busy_mask !== 8'h08) $display("FAIL raw_busy got %h exp 08", busy_mask); else passed++;
      @(negedge clk);
      idle();
      issue_valid = 1'b1; use_a = 1'b1; rd_addr_a = 3'd3;
      #1;
      checks++; if (stall !== 1'b1) $display("FAIL raw_stall1 got %b exp 1", stall); else passed++;
      @(negedge clk);
      #1;
      checks++; if (stall !== 1'b1) $display("FAIL raw_stall2 got %b exp 1", stall); else passed++;
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h55;
      #1;
      checks++; if (stall !== 1'b0) $display("FAIL raw_release got %b exp 0", stall); else passed++;
      checks++; if (rd_data_a !== 8'h55) $display("FAIL raw_bypass got %h exp 55", rd_data_a); else passed++;
      @(posedge clk); #1;
      checks++; if (busy_mask !== 8'h00) $display("FAIL raw_busy_clear got %h exp 00", busy_mask); else passed++;
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idle();
         issue_valid = 1'b1; issue_dst = 3'd2; issue_wr = 1'b1;
         #1;
         checks++; if (stall !== 1'b0) $display("FAIL sat_issue%0d got %b exp 0", i, stall); else passed++;
      end
      @(negedge clk);
      #1;
      checks++; if (stall !== 1'b1) $display("FAIL sat_full got %b exp 1", stall); else passed++;
      checks++; if (busy_mask !== 8'h04) $display("FAIL sat_busy got %h exp 04", busy_mask); else passed++;
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h11;
      #1;
      checks++; if (stall !== 1'b1) $display("FAIL sat_full_retire got %b exp 1", stall); else passed++;
      @(negedge clk);
      idle();
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h22;
      @(negedge clk);
      wr_data = 8'h33;
      #1;
      checks++; if (busy_mask !== 8'h04) $display("FAIL sat_busy_before_last got %h exp 04", busy_mask); else passed++;
      @(posedge clk); #1;
      checks++; if (busy_mask !== 8'h00) $display("FAIL sat_busy_after_last got %h exp 00", busy_mask); else passed++;
      @(negedge clk);
      wr_data = 8'h44;
      @(negedge clk);
      idle();
      issue_valid = 1'b1; use_a = 1'b1; rd_addr_a = 3'd2;
      #1;
      checks++; if (stall !== 1'b0) $display("FAIL sat_no_wrap_stall got %b exp 0", stall); else passed++;
      checks++; if (busy_mask !== 8'h00) $display("FAIL sat_no_wrap_busy got %h exp 00", busy_mask); else passed++;
      checks++; if (rd_data_a !== 8'h44) $display("FAIL sat_last_data got %h exp 44", rd_data_a); else passed++;
   endtask

   task automatic test_simultaneous();
      @(negedge clk);
      idle();
      issue_valid = 1'b1; issue_dst = 3'd4; issue_wr = 1'b1;
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h66;
      #1;
      checks++; if (stall !== 1'b0) $display("FAIL sim_same_stall got %b exp 0", stall); else passed++;
      @(posedge clk); #1;
      checks++; if (busy_mask !== 8'h10) $display("FAIL sim_same_busy got %h exp 10", busy_mask); else passed++;
      @(negedge clk);
      idle();
      issue_valid = 1'b1; issue_dst = 3'd1; issue_wr = 1'b1;
      wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h77;
      #1;
      checks++; if (stall !== 1'b0) $display("FAIL sim_diff_stall got %b exp 0", stall); else passed++;
      @(posedge clk); #1;
      checks++; if (busy_mask !== 8'h02) $display("FAIL sim_diff_busy got %h exp 02", busy_mask); else passed++;
      @(negedge clk);
      idle();
      issue_valid = 1'b1; use_b = 1'b1; rd_addr_b = 3'd1;
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h88;
      #1;
      checks++; if (stall !== 1'b0) $display("FAIL sim_retire_read_stall got %b exp 0", stall); else passed++;
      @(posedge clk); #1;
      checks++; if (busy_mask !== 8'h00) $display("FAIL sim_final_busy got %h exp 00", busy_mask); else passed++;
   endtask

   task automatic test_xaddr();
      @(negedge clk);
      idle();
      issue_valid = 1'b1; issue_dst = 3'd6; issue_wr = 1'b1;
      @(negedge clk);
      idle();
      wr_en = 1'b0; wr_addr = 3'bxxx; wr_data = 8'hxx;
      issue_valid = 1'b1; use_a = 1'b1; rd_addr_a = 3'd6; rd_addr_b = 3'd5;
      #1;
      checks++; if (stall !== 1'b1) $display("FAIL x_stall got %b exp 1", stall); else passed++;
      checks++; if (rd_data_b !== 8'hA7) $display("FAIL x_read got %h exp a7", rd_data_b); else passed++;
      @(posedge clk); #1;
      checks++; if (busy_mask !== 8'h40) $display("FAIL x_busy got %h exp 40", busy_mask); else passed++;
      @(negedge clk);
      idle();
      rd_addr_a = 3'd0; rd_addr_b = 3'd5;
      #1;
      checks++; if (rd_data_a !== 8'h3C) $display("FAIL x_reg0 got %h exp 3c", rd_data_a); else passed++;
      checks++; if (rd_data_b !== 8'hA7) $display("FAIL x_reg5 got %h exp a7", rd_data_b); else passed++;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      idle();
      issue_valid = 1'b1; issue_dst = 3'd7; issue_wr = 1'b1;
      @(negedge clk);
      idle();
      #2;
      reset = 1'b0;
      issue_valid = 1'b1; use_a = 1'b1; rd_addr_a = 3'd6; rd_addr_b = 3'd5;
      #1;
      checks++; if (busy_mask !== 8'h00) $display("FAIL mid_reset_busy got %h exp 00", busy_mask); else passed++;
      checks++; if (stall !== 1'b0) $display("FAIL mid_reset_stall got %b exp 0", stall); else passed++;
      checks++; if (rd_data_b !== 8'h00) $display("FAIL mid_reset_rd got %h exp 00", rd_data_b); else passed++;
      @(negedge clk);
      idle();
      reset = 1'b1;
      rd_addr_a = 3'd0;
      #1;
      checks++; if (rd_data_a !== 8'h00) $display("FAIL post_reset_reg0 got %h exp 00", rd_data_a); else passed++;
   endtask

   initial begin
      rd_addr_a = 3'd0;
      rd_addr_b = 3'd0;
      test_reset();
      test_write_read();
      test_raw_stall();
      test_saturation();
      test_simultaneous();
      test_xaddr();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
